// File: rtl/twenty_bit_serial_subtractor_if.sv
// Handshake and data bundle for the 20-bit serial subtractor.
// The master issues start/a/b and the slave returns status and result.
interface twenty_bit_serial_subtractor_if #(
   parameter int WIDTH = 20
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   modport master (
      output start, a, b,
      input  ready, done, diff, borrow, zero
   );

   modport slave (
      input  start, a, b,
      output ready, done, diff, borrow, zero
   );
endinterface

// File: rtl/twenty_bit_serial_subtractor.sv
// Multi-cycle 20-bit unsigned subtractor: one 4-bit nibble per clock, LSB nibble first,
// with the ripple borrow carried in a flop. Results change only when an operation completes.
module twenty_bit_serial_subtractor #(
   parameter int WIDTH = 20,
   parameter int NIB   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   twenty_bit_serial_subtractor_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [2:0] LAST = 3'(WIDTH / NIB - 1);

   logic [0:0]       state;
   logic [2:0]       cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             bflop;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             zero_q;
   logic             done_q;

   logic [NIB:0]     sub;
   logic [WIDTH-1:0] shadow_next;

   // Operands shift right each cycle, so the active nibble is always at the bottom;
   // result nibbles enter at the top and reach their final position after the last step.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      sub         = {1'b0, op_a[NIB-1:0]} - {1'b0, op_b[NIB-1:0]} - {{NIB{1'b0}}, bflop};
      shadow_next = {sub[NIB-1:0], shadow[WIDTH-1:NIB]};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         bflop    <= 1'b0;
         shadow   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a  <= bus.a;
                  op_b  <= bus.b;
                  bflop <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               op_a   <= op_a >> NIB;
               op_b   <= op_b >> NIB;
               shadow <= shadow_next;
               bflop  <= sub[NIB];
               cnt    <= cnt + 3'd1;
               if (cnt == LAST) begin
                  diff_q   <= shadow_next;
                  borrow_q <= sub[NIB];
                  zero_q   <= (shadow_next == '0);
                  done_q   <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready  = (state == IDLE);
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
   assign bus.zero   = zero_q;
endmodule

// File: tb/tb_twenty_bit_serial_subtractor.sv
// Self-checking bench: directed and random subtractions against a plain-arithmetic model,
// plus handshake timing, ignored starts, back-to-back issue and reset abort.
module tb_twenty_bit_serial_subtractor;
   localparam int W = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;

   twenty_bit_serial_subtractor_if #(.WIDTH(W)) bus ();

   twenty_bit_serial_subtractor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_diff   = '0;
   logic         exp_borrow = 1'b0;
   logic         exp_zero   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: signed difference of the unsigned operands, wrapped into 20 bits.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y);
      longint d;
      d          = longint'(x) - longint'(y);
      exp_borrow = (d < 0);
      if (d < 0) d += (longint'(1) << W);
      exp_diff   = W'(d);
      exp_zero   = (d == 0);
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_diff"},   32'(bus.diff), 32'(exp_diff));
      check({tag, "_borrow"}, 32'(bus.borrow), 32'(exp_borrow));
      check({tag, "_zero"},   32'(bus.zero), 32'(exp_zero));
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb,
                        input string tag);
      logic [W-1:0] old_diff;
      bit           ready_ok;
      bit           hold_ok;
      int           k;
      old_diff = exp_diff;
      ready_ok = 1'b1;
      hold_ok  = 1'b1;
      k        = 0;
      check({tag, "_ready_in"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(negedge clk);
      while (bus.done !== 1'b1 && k < 12) begin
         if (bus.ready !== 1'b0) ready_ok = 1'b0;
         if (bus.diff !== old_diff) hold_ok = 1'b0;
         bus.start = disturb && (k == 1);
         if (disturb && k == 1) begin
            bus.a = 20'd9;
            bus.b = 20'd9;
         end else begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      check({tag, "_latency"},   32'(k), 32'd5);
      check({tag, "_ready_low"}, 32'(ready_ok), 32'd1);
      check({tag, "_diff_hold"}, 32'(hold_ok), 32'd1);
      model(x, y);
      check_outputs(tag);
      check({tag, "_ready_done"}, 32'(bus.ready), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int  pulses;
      int  first;
      int  prev;
      bit  interval_ok;
      bit  val_ok;
      bit  saw_done;
      int  guard;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_done",  32'(bus.done), 32'd0);
      check_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      do_op(20'd0,       20'd0,       1'b0, "zero_zero");
      do_op(20'd222,     20'd111,     1'b0, "d222_111");
      do_op(20'd1000,    20'd1000,    1'b0, "d1000_1000");
      do_op(20'd0,       20'd1,       1'b0, "wrap");
      do_op(20'hFFFFF,   20'd0,       1'b0, "max_0");
      do_op(20'h10000,   20'h00001,   1'b0, "ripple");
      do_op(20'd500,     20'd200,     1'b1, "ignored_start");

      // Continuous start: one result every 6 cycles.
      bus.start   = 1'b1;
      bus.a       = 20'd7;
      bus.b       = 20'd3;
      pulses      = 0;
      first       = -1;
      prev        = -1;
      interval_ok = 1'b1;
      val_ok      = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (first >= 0 && (bus.diff !== 20'd4 || bus.borrow !== 1'b0 || bus.zero !== 1'b0))
            val_ok = 1'b0;
         if (bus.done === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
            else if (c - prev != 6) interval_ok = 1'b0;
            if (bus.diff !== 20'd4) val_ok = 1'b0;
            prev = c;
         end
      end
      bus.start = 1'b0;
      check("b2b_first_done", 32'(first), 32'd6);
      check("b2b_pulses",     32'(pulses), 32'd4);
      check("b2b_interval",   32'(interval_ok), 32'd1);
      check("b2b_value",      32'(val_ok), 32'd1);
      guard = 0;
      while (!(bus.ready === 1'b1 && bus.done === 1'b0) && guard < 12) begin
         @(negedge clk);
         guard++;
      end
      check("b2b_drain", 32'(guard < 12), 32'd1);
      model(20'd7, 20'd3);

      // Reset in the middle of an operation aborts it.
      bus.start = 1'b1;
      bus.a     = 20'd50;
      bus.b     = 20'd60;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_diff   = '0;
      exp_borrow = 1'b0;
      exp_zero   = 1'b0;
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_done",  32'(bus.done), 32'd0);
      check_outputs("abort");
      saw_done = 1'b0;
      repeat (7) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      do_op(20'd60, 20'd50, 1'b0, "after_abort");

      // Reset and start together: start is dropped.
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 20'd5;
      bus.b     = 20'd1;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      exp_diff   = '0;
      exp_borrow = 1'b0;
      exp_zero   = 1'b0;
      check("rst_start_ready", 32'(bus.ready), 32'd1);
      saw_done = 1'b0;
      repeat (7) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("rst_start_no_done", 32'(saw_done), 32'd0);
      check_outputs("rst_start");

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         do_op(ra, rb, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
